// File: rtl/sample_framer.sv
// sample_framer
//   Buffers 16-bit decimated samples in a FIFO and packs them into fixed-length
//   byte frames for a byte-wide UART transmitter:
//     HDR, SEQ, RATE, FRAME_LEN x (sample MSB, sample LSB), CSUM
//   CSUM is the XOR of every byte from HDR through the last sample LSB.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high; empties FIFO, aborts any frame
//   drdy       in   one-cycle strobe, datain valid
//   datain     in   [15:0] decimated sample
//   rate       in   [2:0] decimation select, latched at frame start
//   tx_busy    in   UART busy
//   tx_start   out  one-cycle strobe, tx_data valid and accepted by UART
//   tx_data    out  [7:0] byte to transmit (0 when not strobing)
//   overflow   out  sticky: a sample was dropped because the FIFO was full
//   fifo_level out  [$clog2(DEPTH):0] words held in the FIFO
`timescale 1ns/1ps
module sample_framer #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned FRAME_LEN = 8,
  parameter logic [7:0]  HDR       = 8'hA5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     drdy,
  input  logic [15:0]              datain,
  input  logic [2:0]               rate,
  input  logic                     tx_busy,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_SEQ, S_RATE, S_MSB, S_LSB, S_CSUM, S_GAP
  } state_t;

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q;
  logic          ovf_q;
  logic [15:0]   word_q;

  state_t        state_q, state_d;
  state_t        ret_q, ret_d;
  logic [7:0]    seq_q, seq_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [2:0]    rate_q, rate_d;

  logic          full, push, pop;
  logic          is_send, issue;
  logic [7:0]    send_byte;
  state_t        after_send;

  // Full is judged on the pre-cycle level, so a same-cycle pop never makes room.
  assign full  = (level_q == LW'(DEPTH));
  assign push  = drdy && !full;

  assign is_send = (state_q != S_IDLE) && (state_q != S_GAP);
  assign issue   = is_send && !tx_busy;

  // FIFO storage has no reset; emptiness is carried entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= datain;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      word_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
        word_q <= mem_q[rptr_q];
      end
      if (drdy && full) ovf_q <= 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ret_q   <= S_IDLE;
      seq_q   <= '0;
      csum_q  <= '0;
      cnt_q   <= '0;
      rate_q  <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      seq_q   <= seq_d;
      csum_q  <= csum_d;
      cnt_q   <= cnt_d;
      rate_q  <= rate_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    seq_d      = seq_q;
    csum_d     = csum_q;
    cnt_d      = cnt_q;
    rate_d     = rate_q;
    pop        = 1'b0;
    send_byte  = 8'h00;
    after_send = S_IDLE;
    tx_start   = 1'b0;
    tx_data    = 8'h00;

    case (state_q)
      S_IDLE: begin
        // Only start once the whole frame is buffered so MSB never finds the FIFO empty.
        if (level_q >= LW'(FRAME_LEN)) begin
          state_d = S_HDR;
          rate_d  = rate;
          csum_d  = '0;
          cnt_d   = '0;
        end
      end
      S_HDR: begin
        send_byte  = HDR;
        after_send = S_SEQ;
      end
      S_SEQ: begin
        send_byte  = seq_q;
        after_send = S_RATE;
      end
      S_RATE: begin
        send_byte  = {5'b0, rate_q};
        after_send = S_MSB;
      end
      S_MSB: begin
        // MSB comes straight from the FIFO head; the word is captured for the LSB.
        send_byte  = mem_q[rptr_q][15:8];
        after_send = S_LSB;
        pop        = issue;
      end
      S_LSB: begin
        send_byte  = word_q[7:0];
        after_send = (({1'b0, cnt_q} + 9'd1) < 9'(FRAME_LEN)) ? S_MSB : S_CSUM;
        if (issue) cnt_d = cnt_q + 8'd1;
      end
      S_CSUM: begin
        send_byte  = csum_q;
        after_send = S_IDLE;
        if (issue) seq_d = seq_q + 8'd1;
      end
      S_GAP: begin
        state_d = ret_q;
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      tx_start = 1'b1;
      tx_data  = send_byte;
      csum_d   = csum_q ^ send_byte;
      ret_d    = after_send;
      state_d  = S_GAP;
    end
  end

  assign overflow   = ovf_q;
  assign fifo_level = level_q;

endmodule
